// File: rtl/vga_scan_timing.sv
// Raster scan timing for a VGA display: pixel enable, scan coordinates, sync/blank
// and a registered RGB stage aligned one pixel behind the coordinates.
module vga_scan_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  HT_LAST  = 10'(HT - 1);
    localparam logic [9:0]  VT_LAST  = 10'(VT - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 does not wrap.
    localparam logic [10:0] H_ACT    = 11'(H_VISIBLE);
    localparam logic [10:0] V_ACT    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       div_q, div_d;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_n_q, blank_n_d;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;
    logic       fs_q, fs_d;

    logic       pix_en;
    logic       h_wrap;
    logic       v_wrap;
    logic       active;
    logic [10:0] hc_w;
    logic [10:0] vc_w;

    always_comb begin
        pix_en    = div_q;
        div_d     = ~div_q;
        hc_d      = hc_q;
        vc_d      = vc_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        fs_d      = 1'b0;

        hc_w   = {1'b0, hc_q};
        vc_w   = {1'b0, vc_q};
        h_wrap = (hc_q == HT_LAST);
        v_wrap = (vc_q == VT_LAST);
        active = (hc_w < H_ACT) && (vc_w < V_ACT);

        if (pix_en) begin
            hc_d = h_wrap ? 10'd0 : hc_q + 10'd1;
            if (h_wrap) begin
                vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
            end
            // Output stage samples the pre-increment coordinates.
            hs_d      = !((hc_w >= HS_START) && (hc_w < HS_END));
            vs_d      = !((vc_w >= VS_START) && (vc_w < VS_END));
            blank_n_d = active;
            r_d       = active ? Red_in   : 8'h00;
            g_d       = active ? Green_in : 8'h00;
            b_d       = active ? Blue_in  : 8'h00;
            fs_d      = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q     <= 1'b0;
            hc_q      <= 10'd0;
            vc_q      <= 10'd0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= 8'h00;
            g_q       <= 8'h00;
            b_q       <= 8'h00;
            fs_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            fs_q      <= fs_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign frame_start = fs_q;
    assign VGA_CLK     = div_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench for vga_scan_timing: a full-size instance for line timing and
// alignment, plus a shrunken-raster instance so whole frames fit in a short run.
module tb_vga_scan_timing;

    logic clk_sys = 1'b0;
    always #10 clk_sys = ~clk_sys;

    logic       reset_big, reset_sm;
    logic       sm_red_x;

    logic [9:0] big_x, big_y;
    logic       big_fs, big_vclk, big_hs, big_vs, big_bn, big_sn;
    logic [7:0] big_r, big_g, big_b;
    logic [7:0] big_red, big_grn, big_blu;

    logic [9:0] sm_x, sm_y;
    logic       sm_fs, sm_vclk, sm_hs, sm_vs, sm_bn, sm_sn;
    logic [7:0] sm_r, sm_g, sm_b;
    logic [7:0] sm_red, sm_grn, sm_blu;

    assign big_red = big_x[7:0];
    assign big_grn = 8'h55;
    assign big_blu = 8'hFF;
    assign sm_red  = sm_red_x ? sm_x[7:0] : 8'hAA;
    assign sm_grn  = 8'h55;
    assign sm_blu  = 8'hFF;

    vga_scan_timing u_big (
        .Clk(clk_sys), .Reset(reset_big),
        .Red_in(big_red), .Green_in(big_grn), .Blue_in(big_blu),
        .DrawX(big_x), .DrawY(big_y), .frame_start(big_fs),
        .VGA_CLK(big_vclk), .VGA_HS(big_hs), .VGA_VS(big_vs),
        .VGA_BLANK_N(big_bn), .VGA_SYNC_N(big_sn),
        .VGA_R(big_r), .VGA_G(big_g), .VGA_B(big_b)
    );

    // 16 x 9 raster: visible 8x4, HS low hc 10..12, VS low vc 5..6, frame = 288 Clk.
    vga_scan_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u_sm (
        .Clk(clk_sys), .Reset(reset_sm),
        .Red_in(sm_red), .Green_in(sm_grn), .Blue_in(sm_blu),
        .DrawX(sm_x), .DrawY(sm_y), .frame_start(sm_fs),
        .VGA_CLK(sm_vclk), .VGA_HS(sm_hs), .VGA_VS(sm_vs),
        .VGA_BLANK_N(sm_bn), .VGA_SYNC_N(sm_sn),
        .VGA_R(sm_r), .VGA_G(sm_g), .VGA_B(sm_b)
    );

    int checks   = 0;
    int failures = 0;
    int nb       = 0;
    int ns       = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step_b();
        @(negedge clk_sys);
        nb++;
    endtask

    task automatic step_s();
        @(negedge clk_sys);
        ns++;
    endtask

    task automatic advance_b(input int target);
        while (nb < target) step_b();
    endtask

    task automatic check_big_reset(input string tag);
        check({tag, "_x"},    32'(big_x),    32'd0);
        check({tag, "_y"},    32'(big_y),    32'd0);
        check({tag, "_vclk"}, 32'(big_vclk), 32'd0);
        check({tag, "_hs"},   32'(big_hs),   32'd1);
        check({tag, "_vs"},   32'(big_vs),   32'd1);
        check({tag, "_bn"},   32'(big_bn),   32'd0);
        check({tag, "_r"},    32'(big_r),    32'd0);
        check({tag, "_g"},    32'(big_g),    32'd0);
        check({tag, "_b"},    32'(big_b),    32'd0);
        check({tag, "_fs"},   32'(big_fs),   32'd0);
    endtask

    initial begin
        int lowcnt, hi, tog, fall1;
        logic prev;
        int vs_low, vs_fall_n, vs_fall_x, vs_fall_y, blank_cnt, rgb_bad, fs_cnt, fs_n;
        logic vs_prev;

        reset_big = 1'b1;
        reset_sm  = 1'b1;
        sm_red_x  = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_big_reset("init");
        check("init_sync_n", 32'(big_sn), 32'd0);

        reset_big = 1'b0;
        nb = 0;

        // Red follows DrawX, so VGA_R shows the X of the pixel one slot earlier.
        advance_b(11);
        check("align_x4_r",  32'(big_r),  32'h04);
        check("align_x4_bn", 32'(big_bn), 32'd1);
        advance_b(12);
        check("align_x5_r",  32'(big_r),  32'h05);
        check("align_x5_g",  32'(big_g),  32'h55);
        check("align_x5_b",  32'(big_b),  32'hFF);

        advance_b(1281);
        check("x639_bn", 32'(big_bn), 32'd1);
        check("x639_r",  32'(big_r),  32'h7F);
        advance_b(1282);
        check("x640_bn", 32'(big_bn), 32'd0);
        check("x640_r",  32'(big_r),  32'h00);
        check("x640_g",  32'(big_g),  32'h00);
        check("x640_b",  32'(big_b),  32'h00);

        while (big_hs !== 1'b0 && nb < 2000) step_b();
        fall1 = nb;
        check("hs_fall_at", 32'(nb), 32'd1314);
        check("hs_fall_x",  32'(big_x), 32'd657);
        lowcnt = 0;
        while (big_hs === 1'b0 && lowcnt < 400) begin
            lowcnt++;
            step_b();
        end
        check("hs_low_clk", 32'(lowcnt), 32'd192);

        advance_b(1599);
        check("wrap_pre_x", 32'(big_x), 32'd799);
        check("wrap_pre_y", 32'(big_y), 32'd0);
        advance_b(1600);
        check("wrap_post_x", 32'(big_x), 32'd0);
        check("wrap_post_y", 32'(big_y), 32'd1);

        while (big_hs !== 1'b0 && nb < 4000) step_b();
        check("line_period", 32'(nb - fall1), 32'd1600);

        advance_b(3800);
        check("mid_x",  32'(big_x),  32'd300);
        check("mid_y",  32'(big_y),  32'd2);
        check("mid_bn", 32'(big_bn), 32'd1);
        check("mid_r",  32'(big_r),  32'h2B);
        check("mid_sync_n", 32'(big_sn), 32'd0);

        reset_big = 1'b1;
        step_b();
        check("rst1_x", 32'(big_x), 32'd0);
        step_b();
        step_b();
        check_big_reset("rst3");
        reset_big = 1'b0;
        nb = 0;
        step_b();
        check("rel1_x",    32'(big_x),    32'd0);
        check("rel1_vclk", 32'(big_vclk), 32'd1);
        step_b();
        check("rel2_x",    32'(big_x),    32'd1);
        check("rel2_vclk", 32'(big_vclk), 32'd0);
        check("rel2_bn",   32'(big_bn),   32'd1);
        check("rel2_r",    32'(big_r),    32'h00);

        hi = 0;
        tog = 0;
        prev = big_vclk;
        repeat (20) begin
            step_b();
            if (big_vclk === 1'b1) hi++;
            if (big_vclk !== prev) tog++;
            prev = big_vclk;
        end
        check("vclk_high", 32'(hi),  32'd10);
        check("vclk_tog",  32'(tog), 32'd20);
        check("end_sync_n", 32'(big_sn), 32'd0);

        // Shrunken raster: whole frames.
        check("sm_rst_x",  32'(sm_x),  32'd0);
        check("sm_rst_vs", 32'(sm_vs), 32'd1);
        check("sm_rst_bn", 32'(sm_bn), 32'd0);
        reset_sm = 1'b0;
        ns = 0;
        vs_low = 0; vs_fall_n = -1; vs_fall_x = -1; vs_fall_y = -1;
        blank_cnt = 0; rgb_bad = 0; fs_cnt = 0; fs_n = -1;
        vs_prev = 1'b1;
        while (ns < 288) begin
            step_s();
            if (sm_vs === 1'b0) vs_low++;
            if (sm_vs === 1'b0 && vs_prev === 1'b1 && vs_fall_n < 0) begin
                vs_fall_n = ns;
                vs_fall_x = int'(sm_x);
                vs_fall_y = int'(sm_y);
            end
            vs_prev = sm_vs;
            if (sm_bn === 1'b1) begin
                blank_cnt++;
                if ({sm_r, sm_g, sm_b} !== 24'hAA55FF) rgb_bad++;
            end else if ({sm_r, sm_g, sm_b} !== 24'h000000) begin
                rgb_bad++;
            end
            if (sm_fs === 1'b1) begin
                fs_cnt++;
                fs_n = ns;
            end
            if (ns == 17) begin
                check("sm_x7_bn",  32'(sm_bn), 32'd1);
                check("sm_x7_rgb", 32'({sm_r, sm_g, sm_b}), 32'hAA55FF);
            end
            if (ns == 18) begin
                check("sm_x8_bn",  32'(sm_bn), 32'd0);
                check("sm_x8_rgb", 32'({sm_r, sm_g, sm_b}), 32'h000000);
            end
        end
        check("sm_vs_fall_n", 32'(vs_fall_n), 32'd162);
        check("sm_vs_fall_x", 32'(vs_fall_x), 32'd1);
        check("sm_vs_fall_y", 32'(vs_fall_y), 32'd5);
        check("sm_vs_low",    32'(vs_low),    32'd64);
        check("sm_blank_cnt", 32'(blank_cnt), 32'd64);
        check("sm_rgb_bad",   32'(rgb_bad),   32'd0);
        check("sm_fs_cnt",    32'(fs_cnt),    32'd1);
        check("sm_fs_n",      32'(fs_n),      32'd288);
        check("sm_wrap_x",    32'(sm_x),      32'd0);
        check("sm_wrap_y",    32'(sm_y),      32'd0);

        sm_red_x = 1'b1;
        step_s();
        check("sm_fs_width", 32'(sm_fs), 32'd0);
        check("sm_289_bn",   32'(sm_bn), 32'd0);
        step_s();
        check("sm_290_bn", 32'(sm_bn), 32'd1);
        check("sm_290_r",  32'(sm_r),  32'h00);
        check("sm_290_g",  32'(sm_g),  32'h55);
        step_s();
        step_s();
        check("sm_292_r", 32'(sm_r), 32'h01);

        while (sm_fs !== 1'b1 && ns < 1000) step_s();
        check("sm_frame_period", 32'(ns - 288), 32'd288);
        step_s();
        check("sm_fs2_width", 32'(sm_fs), 32'd0);

        while (!(sm_vs === 1'b0 && sm_hs === 1'b0) && ns < 1200) step_s();
        check("sm_hs_vs_low_at", 32'(ns), 32'd758);
        reset_sm = 1'b1;
        repeat (3) step_s();
        check("sm_rst_hs",   32'(sm_hs),   32'd1);
        check("sm_rst2_vs",  32'(sm_vs),   32'd1);
        check("sm_rst2_x",   32'(sm_x),    32'd0);
        check("sm_rst2_y",   32'(sm_y),    32'd0);
        check("sm_rst2_vclk", 32'(sm_vclk), 32'd0);
        check("sm_rst2_r",   32'(sm_r),    32'd0);
        check("sm_rst2_fs",  32'(sm_fs),   32'd0);
        check("sm_sync_n",   32'(sm_sn),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
